pipe_adder: RTL and testbench



---
 rtl/pipe_adder_if.sv | 33 +++
 rtl/pipe_adder.sv | 136 +++++++++++++
 tb/tb_pipe_adder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// pipe_adder_if
// Groups the operand/result handshake of pipe_adder into one bundle.
//   in_valid/in_ready   : operand handshake (master -> slave)
//   a, b, cin, sub      : operands, carry/borrow-in, mode (0 add, 1 sub)
//   out_valid/out_ready : result handshake (slave -> master)
//   sum, cout, ovf      : result, raw carry out of the adder, signed overflow
// The master modport is the side that supplies operands and consumes results;
// the slave modport is the adder itself.
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder
// Pipelined two's-complement adder/subtractor. The carry chain is cut into
// STAGES = WIDTH/CHUNK chunks; stage k adds bits [k*CHUNK +: CHUNK] using the
// registered carry of stage k-1. Unconsumed operand bits ride along in skew
// registers that shrink by CHUNK bits per stage, finished low sum bits grow by
// CHUNK bits per stage. The whole pipe shifts together (no bubble squeezing).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears stage valid bits only)
//   bus   : pipe_adder_if.slave (operand and result handshakes, see interface)
// Result data registers are not reset; sum/cout/ovf are forced to zero while
// out_valid is low so the outputs read zero during and after reset.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_adder_if.slave  bus
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // One chunk of the ripple: {carry_out, sum_chunk}.
  function automatic logic [CHUNK:0] add_chunk(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             ci
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  // Signed overflow: operands agree in sign, result does not.
  function automatic logic signed_ovf(
    input logic sa,
    input logic sb,
    input logic ss
  );
    return (sa == sb) && (ss != sa);
  endfunction

  // Subtraction is A + ~B + !borrow_in, so fold the mode into B and cin
  // before the first stage; later stages never see sub.
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ? ~bus.cin : bus.cin;

  // The pipe moves only when the output slot is empty or being drained.
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stg
      localparam int IN_W   = WIDTH - k * CHUNK;   // operand bits still pending
      localparam int REM_W  = IN_W - CHUNK;        // left over after this chunk
      localparam int DONE_W = (k + 1) * CHUNK;     // sum bits finished here

      logic [IN_W-1:0]   op_a;
      logic [IN_W-1:0]   op_b;
      logic              c_in;
      logic              v_in;
      logic              sa_in;
      logic              sb_in;
      logic [CHUNK:0]    add_w;
      logic [DONE_W-1:0] done_nxt;

      logic              vld_p;
      logic              c_p;
      logic              sa_p;
      logic              sb_p;
      logic [DONE_W-1:0] sum_p;

      if (k == 0) begin : g_src
        assign op_a     = bus.a;
        assign op_b     = b_eff;
        assign c_in     = cin_eff;
        assign v_in     = bus.in_valid;
        assign sa_in    = bus.a[WIDTH-1];
        assign sb_in    = b_eff[WIDTH-1];
        assign done_nxt = add_w[CHUNK-1:0];
      end else begin : g_src
        assign op_a     = g_stg[k-1].g_skew.a_p;
        assign op_b     = g_stg[k-1].g_skew.b_p;
        assign c_in     = g_stg[k-1].c_p;
        assign v_in     = g_stg[k-1].vld_p;
        assign sa_in    = g_stg[k-1].sa_p;
        assign sb_in    = g_stg[k-1].sb_p;
        assign done_nxt = {add_w[CHUNK-1:0], g_stg[k-1].sum_p};
      end

      assign add_w = add_chunk(op_a[CHUNK-1:0], op_b[CHUNK-1:0], c_in);

      // ---- stage k register boundary ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p <= 1'b0;
        end else if (advance) begin
          vld_p <= v_in;
        end
      end

      always_ff @(posedge clk) begin
        if (advance && v_in) begin
          sum_p <= done_nxt;
          c_p   <= add_w[CHUNK];
          sa_p  <= sa_in;
          sb_p  <= sb_in;
        end
      end

      if (REM_W > 0) begin : g_skew
        logic [REM_W-1:0] a_p;
        logic [REM_W-1:0] b_p;

        always_ff @(posedge clk) begin
          if (advance && v_in) begin
            a_p <= op_a[IN_W-1:CHUNK];
            b_p <= op_b[IN_W-1:CHUNK];
          end
        end
      end
    end
  endgenerate

  assign bus.out_valid = g_stg[STAGES-1].vld_p;
  assign bus.sum       = bus.out_valid ? g_stg[STAGES-1].sum_p : '0;
  assign bus.cout      = bus.out_valid && g_stg[STAGES-1].c_p;
  assign bus.ovf       = bus.out_valid &&
                         signed_ovf(g_stg[STAGES-1].sa_p, g_stg[STAGES-1].sb_p,
                                    g_stg[STAGES-1].sum_p[WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder
// Directed bench for pipe_adder: a 16-bit/4-bit-chunk instance for the main
// scenarios and a 1-bit/1-chunk instance exercised as a registered half adder.
// All stimulus changes and output sampling happen on the falling clock edge.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(16)) bus16 ();
  pipe_adder_if #(.WIDTH(1))  bus1 ();

  pipe_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  pipe_adder #(.WIDTH(1),  .CHUNK(1)) dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Presents one operand set for exactly one cycle; caller guarantees in_ready.
  task automatic send_one(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub;
    bus16.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0;
  endtask

  // Counts edges since the accepting edge until out_valid shows (bounded).
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!bus16.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
    bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus16.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus16.out_valid); end
    n_checks++; if (bus16.sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got %h want 0000", bus16.sum); end
    n_checks++; if (bus16.cout !== 1'b0 || bus16.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_flags got cout=%b ovf=%b want 0 0", bus16.cout, bus16.ovf); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus16.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus16.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_carry_wrap();
    int cyc;
    send_one(16'h0001, 16'hFFFF, 1'b0, 1'b0);
    wait_out(cyc);
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL wrap_latency got %0d want 4", cyc); end
    n_checks++; if (bus16.sum !== 16'h0000) begin n_fail++; $display("FAIL wrap_sum got %h want 0000", bus16.sum); end
    n_checks++; if (bus16.cout !== 1'b1 || bus16.ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_flags got cout=%b ovf=%b want 1 0", bus16.cout, bus16.ovf); end
  endtask

  task automatic test_signed_overflow();
    int cyc;
    send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_out(cyc);
    n_checks++; if (cyc !== 4 || bus16.sum !== 16'h8000) begin n_fail++; $display("FAIL ovf_add_sum got %h at %0d want 8000 at 4", bus16.sum, cyc); end
    n_checks++; if (bus16.cout !== 1'b0 || bus16.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_add_flags got cout=%b ovf=%b want 0 1", bus16.cout, bus16.ovf); end
    send_one(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_out(cyc);
    n_checks++; if (cyc !== 4 || bus16.sum !== 16'h7FFF) begin n_fail++; $display("FAIL ovf_sub_sum got %h at %0d want 7fff at 4", bus16.sum, cyc); end
    n_checks++; if (bus16.cout !== 1'b1 || bus16.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sub_flags got cout=%b ovf=%b want 1 1", bus16.cout, bus16.ovf); end
  endtask

  task automatic test_borrow();
    int cyc;
    send_one(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_out(cyc);
    n_checks++; if (cyc !== 4 || bus16.sum !== 16'hFFFE) begin n_fail++; $display("FAIL borrow_sum got %h at %0d want fffe at 4", bus16.sum, cyc); end
    n_checks++; if (bus16.cout !== 1'b0 || bus16.ovf !== 1'b0) begin n_fail++; $display("FAIL borrow_flags got cout=%b ovf=%b want 0 0", bus16.cout, bus16.ovf); end
    send_one(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_out(cyc);
    n_checks++; if (cyc !== 4 || bus16.sum !== 16'hFFFD) begin n_fail++; $display("FAIL borrow_cin_sum got %h at %0d want fffd at 4", bus16.sum, cyc); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [4] = '{16'h1234, 16'h1000, 16'hFFFF, 16'h0000};
    logic [15:0] vb [4] = '{16'h4321, 16'h0001, 16'hFFFF, 16'h0000};
    logic        vc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        vs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] es [4] = '{16'h5556, 16'h0FFF, 16'hFFFF, 16'hFFFF};
    logic        ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int got = 0;
    int first_t = -1;
    int last_t = -1;
    @(negedge clk);
    for (int t = 0; t < 12; t++) begin
      if (bus16.out_valid && got < 4) begin
        n_checks++; if (bus16.sum !== es[got] || bus16.cout !== ec[got] || bus16.ovf !== 1'b0) begin
          n_fail++; $display("FAIL b2b_result%0d got %h c=%b v=%b want %h c=%b v=0", got, bus16.sum, bus16.cout, bus16.ovf, es[got], ec[got]);
        end
        if (first_t < 0) first_t = t;
        last_t = t;
        got++;
      end
      if (t < 4) begin
        bus16.a = va[t]; bus16.b = vb[t]; bus16.cin = vc[t]; bus16.sub = vs[t];
        bus16.in_valid = 1'b1;
      end else begin
        bus16.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++; if (got !== 4 || first_t !== 4 || last_t !== 7) begin n_fail++; $display("FAIL b2b_timing got n=%0d first=%0d last=%0d want 4 4 7", got, first_t, last_t); end
  endtask

  task automatic test_backpressure();
    int n = 1;
    int got = 0;
    bus16.out_ready = 1'b0;
    bus16.cin = 1'b0; bus16.sub = 1'b0;
    for (int t = 0; t < 10 && bus16.in_ready; t++) begin
      bus16.a = 16'(n); bus16.b = 16'(n * 16'h1000);
      bus16.in_valid = 1'b1;
      n++;
      @(negedge clk);
    end
    // item 5 waits on the bus while the pipe is full
    bus16.a = 16'(n); bus16.b = 16'(n * 16'h1000);
    bus16.in_valid = 1'b1;
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL bp_accepted got %0d want 4", n - 1); end
    for (int t = 0; t < 3; t++) begin
      n_checks++; if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1 || bus16.sum !== 16'h1001) begin
        n_fail++; $display("FAIL bp_hold%0d got rdy=%b vld=%b sum=%h want 0 1 1001", t, bus16.in_ready, bus16.out_valid, bus16.sum);
      end
      @(negedge clk);
    end
    bus16.out_ready = 1'b1;
    for (int t = 0; t < 30 && got < 6; t++) begin
      if (bus16.out_valid) begin
        n_checks++; if (bus16.sum !== 16'(16'h1001 * (got + 1))) begin
          n_fail++; $display("FAIL bp_result%0d got %h want %h", got, bus16.sum, 16'(16'h1001 * (got + 1)));
        end
        got++;
      end
      if (bus16.in_ready && n <= 6) begin
        bus16.a = 16'(n); bus16.b = 16'(n * 16'h1000);
        bus16.in_valid = 1'b1;
        n++;
      end else begin
        bus16.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus16.in_valid = 1'b0;
    n_checks++; if (got !== 6) begin n_fail++; $display("FAIL bp_count got %0d want 6", got); end
    repeat (5) @(negedge clk);
    n_checks++; if (bus16.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got out_valid=%b want 0", bus16.out_valid); end
  endtask

  task automatic test_reset_mid_flight();
    int cyc;
    int extra = 0;
    bus16.out_ready = 1'b1;
    bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus16.in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus16.a = 16'(i); bus16.b = 16'h0100;
      @(negedge clk);
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (bus16.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got %b want 1", bus16.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus16.out_valid !== 1'b0 || bus16.sum !== 16'h0000) begin
      n_fail++; $display("FAIL rst_async_clear got vld=%b sum=%h want 0 0000", bus16.out_valid, bus16.sum);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus16.out_ready = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 6; t++) begin
      if (bus16.out_valid !== 1'b0) extra++;
      @(negedge clk);
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL rst_no_partial got %0d valid cycles want 0", extra); end
    send_one(16'h0102, 16'h0304, 1'b0, 1'b0);
    wait_out(cyc);
    n_checks++; if (cyc !== 4 || bus16.sum !== 16'h0406) begin n_fail++; $display("FAIL rst_next_op got %h at %0d want 0406 at 4", bus16.sum, cyc); end
    @(negedge clk);
  endtask

  task automatic test_half_adder();
    logic ha_a;
    logic ha_b;
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ha_a = i[1];
      ha_b = i[0];
      bus1.a = ha_a; bus1.b = ha_b; bus1.cin = 1'b0; bus1.sub = 1'b0;
      bus1.in_valid = 1'b1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      n_checks++; if (bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL ha_valid%0d got %b want 1", i, bus1.out_valid); end
      n_checks++; if (bus1.sum !== (ha_a ^ ha_b)) begin n_fail++; $display("FAIL ha_sum%0d got %b want %b", i, bus1.sum, ha_a ^ ha_b); end
      n_checks++; if (bus1.cout !== (ha_a & ha_b)) begin n_fail++; $display("FAIL ha_cout%0d got %b want %b", i, bus1.cout, ha_a & ha_b); end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_carry_wrap();
    test_signed_overflow();
    test_borrow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_flight();
    test_half_adder();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
